branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  EX/MEM-side counterpart of the ID-stage branch predictor. Tracks each predicted branch from ID
//  through EX and MEM, resolves its real outcome and compares it with the prediction. On a miss it
//  raises correctAtEX/correctAtMEM, a redirect PC and a younger-instruction kill. It also emits a
//  one-cycle training pulse (index, taken) for the 64-entry 2-bit predictor table.
// PARAMETERS
//  ADDR_W   32  PC / target width
//  CNT_W    32  width of statistics counters (saturating)
//  IDX_W    6   predictor index width; index = pc[IDX_W+1:2]
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       reset, asynchronous, active-high
//  stall          in   1       pipeline hold; tracking slots keep contents
//  id_branch_type in   3       nonzero = branch leaving ID this cycle
//  id_pred_taken  in   1       prediction made in ID for that branch
//  id_pc          in   ADDR_W  branch PC
//  id_target      in   ADDR_W  taken target
//  ex_cond_ready  in   1       EX can resolve the branch in EX (else it defers to MEM)
//  ex_taken       in   1       actual outcome, valid when EX slot busy and ex_cond_ready
//  mem_taken      in   1       actual outcome, valid when MEM slot busy
//  correctAtEX    out  1       mispredict resolved in EX (pulse)
//  correctAtMEM   out  1       mispredict resolved in MEM (pulse)
//  redirect_pc    out  ADDR_W  fetch redirect; target if actually taken, else pc+4
//  kill_younger   out  1       = correctAtEX | correctAtMEM
//  upd_valid      out  1       predictor training pulse
//  upd_idx        out  IDX_W   index of resolved branch
//  upd_taken      out  1       actual outcome of resolved branch
//  branch_cnt     out  CNT_W   resolved branches
//  miss_cnt       out  CNT_W   mispredicted branches
// BEHAVIOUR
//  - Two slots, EX and MEM, each {busy, fired, pred, pc, target}. Slot state: EMPTY, PEND (busy,
//    !fired), DONE (busy, fired). Reset: all slots EMPTY, counters 0, all outputs 0 / redirect_pc 0.
//  - Outputs are combinational from slot registers + ex_taken/mem_taken; an EMPTY or DONE slot
//    contributes nothing, so outputs are 0 at and after reset.
//  - Advance (posedge, !stall): EX<=ID branch (PEND) if id_branch_type!=0, else EMPTY;
//    MEM<=EX slot (fired copied). stall=1: both slots hold; advance is suppressed.
//  - EX resolution: EX PEND and ex_cond_ready -> resolve in that cycle; slot -> DONE at the edge
//    (also under stall), so each branch resolves exactly once. EX PEND with !ex_cond_ready stays
//    PEND and resolves in MEM via mem_taken.
//  - Resolve: upd_valid=1, upd_idx=pc[IDX_W+1:2], upd_taken=actual; miss = pred!=actual raises
//    correctAtEX or correctAtMEM; branch_cnt+1, miss_cnt+1 on miss; both saturate at all-ones.
//  - Kill: correctAtEX -> ID branch presented that edge is dropped (EX loads EMPTY).
//    correctAtMEM -> EX slot and ID branch both dropped; neither is resolved or counted.
//  - Simultaneous EX and MEM resolution: MEM (older) wins. Only MEM drives upd_*/correct/redirect.
//    EX resolution is discarded if MEM misses; if MEM hits, EX is deferred one cycle (stays PEND).
//  - Latency: correct* in the first cycle the branch sits resolvable in its slot, zero extra cycles.
//  - redirect_pc valid only while kill_younger=1; pc+4 wraps modulo 2^ADDR_W.
//  - Reset mid-operation: slots cleared immediately; pending branches are never resolved or counted.
// TESTING
//  - Reset: rst=1 with slots busy -> all outputs 0, counters 0 the same cycle.
//  - EX hit: pc=0x40, pred=1, ex_cond_ready=1, ex_taken=1 -> upd_valid, upd_idx=16, no correct,
//    branch_cnt=1.
//  - EX miss: pc=0x100, tgt=0x200, pred=1, ex_taken=0 -> correctAtEX=1, redirect=0x104,
//    next ID branch dropped, miss_cnt=1.
//  - MEM miss: ex_cond_ready=0, pred=0, mem_taken=1, tgt=0x80 -> correctAtMEM=1 one cycle later,
//    redirect=0x80, EX slot branch dropped.
//  - Stall: EX miss with stall=1 for 3 cycles -> correctAtEX pulses exactly once, counts +1 only.
//  - Collision: MEM hit + EX resolvable the same cycle -> MEM updates first; EX resolves next cycle.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Resolves predicted branches in EX or MEM, raises redirect/kill on a mispredict,
// and emits a one-cycle training pulse plus resolved/missed branch statistics.
module branch_resolve_unit #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [2:0]        id_branch_type,
  input  logic              id_pred_taken,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [ADDR_W-1:0] id_target,
  input  logic              ex_cond_ready,
  input  logic              ex_taken,
  input  logic              mem_taken,
  output logic              correctAtEX,
  output logic              correctAtMEM,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              kill_younger,
  output logic              upd_valid,
  output logic [IDX_W-1:0]  upd_idx,
  output logic              upd_taken,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  typedef struct packed {
    logic              busy;
    logic              fired;
    logic              pred;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
  } slot_t;

  slot_t            ex_q, ex_d, mem_q, mem_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d, miss_cnt_q, miss_cnt_d;
  logic             mem_res, ex_res, mem_miss, ex_miss;

  always_comb begin
    mem_res  = mem_q.busy && !mem_q.fired;
    // MEM holds the older branch, so it takes the single resolve port first
    ex_res   = ex_q.busy && !ex_q.fired && ex_cond_ready && !mem_res;
    mem_miss = mem_res && (mem_q.pred != mem_taken);
    ex_miss  = ex_res && (ex_q.pred != ex_taken);

    correctAtMEM = mem_miss;
    correctAtEX  = ex_miss;
    kill_younger = mem_miss | ex_miss;
    upd_valid    = mem_res | ex_res;
    upd_idx      = '0;
    upd_taken    = 1'b0;
    redirect_pc  = '0;
    if (mem_res) begin
      upd_idx   = mem_q.pc[IDX_W+1:2];
      upd_taken = mem_taken;
      if (mem_miss) redirect_pc = mem_taken ? mem_q.target : mem_q.pc + ADDR_W'(4);
    end else if (ex_res) begin
      upd_idx   = ex_q.pc[IDX_W+1:2];
      upd_taken = ex_taken;
      if (ex_miss) redirect_pc = ex_taken ? ex_q.target : ex_q.pc + ADDR_W'(4);
    end
    branch_cnt = branch_cnt_q;
    miss_cnt   = miss_cnt_q;
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    if (stall) begin
      if (ex_res)   ex_d.fired  = 1'b1;
      if (mem_res)  mem_d.fired = 1'b1;
      if (mem_miss) ex_d        = '0;
    end else begin
      mem_d       = ex_q;
      mem_d.fired = ex_q.fired | ex_res;
      if (mem_miss) mem_d = '0;
      ex_d = '0;
      if (id_branch_type != 3'd0 && !kill_younger) begin
        ex_d.busy   = 1'b1;
        ex_d.pred   = id_pred_taken;
        ex_d.pc     = id_pc;
        ex_d.target = id_target;
      end
    end

    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (upd_valid && branch_cnt_q != '1)     branch_cnt_d = branch_cnt_q + 1'b1;
    if (kill_younger && miss_cnt_q != '1)    miss_cnt_d   = miss_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q         <= '0;
      mem_q        <= '0;
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed scoreboard bench for branch_resolve_unit: stimulus pushes expected resolve events,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_branch_resolve_unit;
  localparam int ADDR_W = 32, CNT_W = 32, IDX_W = 6;

  logic              clk = 0, rst = 1, stall = 0;
  logic [2:0]        id_branch_type = 0;
  logic              id_pred_taken = 0;
  logic [ADDR_W-1:0] id_pc = 0, id_target = 0;
  logic              ex_cond_ready = 0, ex_taken = 0, mem_taken = 0;
  logic              correctAtEX, correctAtMEM, kill_younger, upd_valid, upd_taken;
  logic [ADDR_W-1:0] redirect_pc;
  logic [IDX_W-1:0]  upd_idx;
  logic [CNT_W-1:0]  branch_cnt, miss_cnt;

  branch_resolve_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .id_branch_type(id_branch_type),
    .id_pred_taken(id_pred_taken), .id_pc(id_pc), .id_target(id_target),
    .ex_cond_ready(ex_cond_ready), .ex_taken(ex_taken), .mem_taken(mem_taken),
    .correctAtEX(correctAtEX), .correctAtMEM(correctAtMEM), .redirect_pc(redirect_pc),
    .kill_younger(kill_younger), .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .branch_cnt(branch_cnt), .miss_cnt(miss_cnt));

  always #5 clk = ~clk;

  typedef struct packed {
    logic              cex, cmem, kill;
    logic [ADDR_W-1:0] redir;
    logic [IDX_W-1:0]  idx;
    logic              taken;
    logic [CNT_W-1:0]  bc, mc;
  } ev_t;

  ev_t q[$];
  int  checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic cex, input logic cmem, input logic [ADDR_W-1:0] redir,
                      input logic [IDX_W-1:0] idx, input logic taken,
                      input logic [CNT_W-1:0] bc, input logic [CNT_W-1:0] mc);
    ev_t e;
    e.cex = cex; e.cmem = cmem; e.kill = cex | cmem; e.redir = redir;
    e.idx = idx; e.taken = taken; e.bc = bc; e.mc = mc;
    q.push_back(e);
  endtask

  // Monitor: any resolve-side activity must match the oldest expected event
  always @(negedge clk) begin
    if (!rst && (upd_valid || correctAtEX || correctAtMEM || kill_younger)) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event: upd=%0b cex=%0b cmem=%0b idx=%0d expected no event",
                 upd_valid, correctAtEX, correctAtMEM, upd_idx);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("upd_valid", 64'(upd_valid), 64'(1));
        chk("correct_flags", 64'({correctAtEX, correctAtMEM, kill_younger}),
            64'({e.cex, e.cmem, e.kill}));
        chk("redirect_pc", 64'(redirect_pc), 64'(e.redir));
        chk("upd_idx_taken", 64'({upd_idx, upd_taken}), 64'({e.idx, e.taken}));
        chk("counts", {branch_cnt, miss_cnt}, {e.bc, e.mc});
      end
    end
  end

  // One cycle of stimulus, starting just after a posedge
  task automatic cyc(input logic st, input logic br, input logic pred,
                     input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] tgt,
                     input logic exr, input logic ext, input logic memt);
    stall = st; id_branch_type = br ? 3'd1 : 3'd0; id_pred_taken = pred;
    id_pc = pc; id_target = tgt; ex_cond_ready = exr; ex_taken = ext; mem_taken = memt;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_counts(input string name, input logic [CNT_W-1:0] bc,
                            input logic [CNT_W-1:0] mc);
    @(negedge clk);
    chk(name, {branch_cnt, miss_cnt}, {bc, mc});
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    idle(1);

    // EX hit: pc 0x40 -> idx 16
    cyc(0, 1, 1, 32'h40, 32'h80, 0, 0, 0);
    push(0, 0, 0, 6'd16, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    idle(2);
    chk_counts("cnt_after_ex_hit", 1, 0);

    // Reset while a mispredicting branch sits resolvable in EX
    cyc(0, 1, 1, 32'h100, 32'h200, 0, 0, 0);
    stall = 0; id_branch_type = 0; ex_cond_ready = 1; ex_taken = 0; rst = 1;
    @(negedge clk);
    chk("reset_outputs", 64'({upd_valid, correctAtEX, correctAtMEM, kill_younger, upd_taken}), 64'(0));
    chk("reset_redirect_idx", 64'({redirect_pc, upd_idx}), 64'(0));
    chk("reset_counts", {branch_cnt, miss_cnt}, 64'(0));
    @(posedge clk); #1 rst = 0;
    idle(2);

    // EX miss: redirect pc+4, following ID branch dropped
    cyc(0, 1, 1, 32'h100, 32'h200, 0, 0, 0);
    push(1, 0, 32'h104, 6'd0, 0, 0, 0);
    cyc(0, 1, 0, 32'h300, 32'h400, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 1);
    idle(2);
    chk_counts("cnt_after_ex_miss", 1, 1);

    // MEM miss: deferred branch, younger EX and ID branches dropped
    cyc(0, 1, 0, 32'h60, 32'h80, 0, 0, 0);
    cyc(0, 1, 1, 32'h500, 32'h540, 0, 0, 0);
    push(0, 1, 32'h80, 6'd24, 1, 1, 1);
    cyc(0, 1, 1, 32'h600, 32'h640, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    chk_counts("cnt_after_mem_miss", 2, 2);

    // EX miss held under stall for 3 cycles: single pulse, single count
    cyc(0, 1, 1, 32'h20, 32'h30, 0, 0, 0);
    push(1, 0, 32'h24, 6'd8, 0, 2, 2);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    chk_counts("cnt_after_stall", 3, 3);

    // Collision: MEM hit and EX resolvable together; EX branch resolves next cycle in MEM
    cyc(0, 1, 1, 32'h40, 32'h80, 0, 0, 0);
    cyc(0, 1, 0, 32'h44, 32'h90, 0, 0, 0);
    push(0, 0, 0, 6'd16, 1, 3, 3);
    cyc(0, 0, 0, 0, 0, 1, 0, 1);
    push(0, 0, 0, 6'd17, 0, 4, 3);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    chk_counts("cnt_after_collision", 5, 3);

    chk("scoreboard_drained", 64'(q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
